// File: rtl/uart_tx.sv
// 8N1 UART transmitter behind a small circular byte FIFO with a valid/ready input.
// Latency: byte accepted into an empty FIFO at edge E pops at E+1, txd falls at E+2.
// Backpressure: ready drops while FIFO_DEPTH bytes are queued; queued frames go out back-to-back.
module uart_tx #(
    parameter int _BAUD_SCALE = 10416,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   data_in,
    input  logic                         valid,
    output logic                         ready,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (_BAUD_SCALE > 1) ? $clog2(_BAUD_SCALE) : 1;
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(_BAUD_SCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_end;
    logic fifo_nonempty;

    assign ready         = (count_q != FULL);
    assign push          = valid && ready;
    assign fifo_nonempty = (count_q != '0);
    assign bit_end       = (baud_q == BAUD_LAST);

    // Frame sequencing; pops are decided on the registered count only.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
        end
    end

    // txd is registered from the current state, so it trails the state by one cycle.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign txd   = txd_q;
    assign busy  = (state_q != IDLE);
    assign count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model compared every cycle, a serial
// receiver checking every completed byte, and hand-computed scenario expectations.
module tb_uart_tx;
    localparam int S = 4;
    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       busy;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(._BAUD_SCALE(S), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .txd     (txd),
        .busy    (busy),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Line level of a frame at bit position pos: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    // Reference model: byte queue plus the frame in flight as (byte, cycle offset).
    logic [7:0] mq[$];
    logic [7:0] rx_exp[$];
    logic       m_on = 1'b0;
    logic       m_inframe = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_txd = 1'b1;

    always @(posedge clk or posedge reset) begin
        int   pre;
        logic acc;
        if (reset) begin
            mq.delete();
            rx_exp.delete();
            m_inframe = 1'b0;
            m_t       = 0;
            m_txd     = 1'b1;
            m_on      = 1'b1;
        end else if (m_on) begin
            pre   = mq.size();
            acc   = valid && (pre != D);
            m_txd = m_inframe ? frame_bit(m_cur, m_t / S) : 1'b1;
            if (!m_inframe || m_t == 10*S - 1) begin
                if (pre != 0) begin
                    m_cur     = mq.pop_front();
                    m_inframe = 1'b1;
                    m_t       = 0;
                end else begin
                    m_inframe = 1'b0;
                end
            end else begin
                m_t++;
            end
            if (acc) begin
                mq.push_back(data_in);
                rx_exp.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && m_on) begin
            check("txd",   int'(txd),   int'(m_txd));
            check("busy",  int'(busy),  int'(m_inframe));
            check("count", int'(count), mq.size());
            check("ready", int'(ready), int'(mq.size() != D));
        end
    end

    // Serial receiver: detect start, sample mid-bit, compare against accepted bytes.
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits = '0;
    int         rx_got = 0;

    always @(negedge clk or posedge reset) begin
        logic [7:0] want;
        if (reset) begin
            rx_on  = 1'b0;
            rx_cnt = 0;
        end else if (m_on) begin
            if (!rx_on) begin
                if (txd == 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_on && (rx_cnt % S) == S/2) begin
                rx_bits[rx_cnt / S] = txd;
                if (rx_cnt / S == 9) begin
                    rx_on = 1'b0;
                    rx_got++;
                    check("rx_start", int'(rx_bits[0]), 0);
                    check("rx_stop",  int'(rx_bits[9]), 1);
                    if (rx_exp.size() == 0) begin
                        check("rx_unexpected_byte", int'(rx_bits[8:1]), -1);
                    end else begin
                        want = rx_exp.pop_front();
                        check("rx_byte", int'(rx_bits[8:1]), int'(want));
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [7:0] b, output int stall);
        stall   = 0;
        valid   = 1'b1;
        data_in = b;
        while (!ready && stall < 500) begin
            @(negedge clk);
            stall++;
        end
        check("push_timeout", int'(stall < 500), 1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || count != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    int   a5_pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic tx_s[45];
    logic bz_s[45];
    int   stall;
    int   nbusy;

    initial begin
        valid   = 1'b0;
        data_in = 8'h00;
        reset   = 1'b0;

        // Reset asserted between edges takes effect without a clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_txd",   int'(txd),   1);
        check("rst_busy",  int'(busy),  0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Single byte A5.
        push(8'hA5, stall);
        for (int j = 0; j < 45; j++) begin
            tx_s[j] = txd;
            bz_s[j] = busy;
            @(negedge clk);
        end
        check("a5_before_fall", int'(tx_s[1]), 1);
        check("a5_fall_at_2",   int'(tx_s[2]), 0);
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < S; c++)
                check("a5_bit", int'(tx_s[2 + k*S + c]), a5_pat[k]);
        check("a5_after", int'(tx_s[42]), 1);
        nbusy = 0;
        for (int j = 0; j < 45; j++) nbusy += int'(bz_s[j]);
        check("a5_busy_cycles", nbusy, 40);
        check("a5_busy_at_0", int'(bz_s[0]), 0);
        check("a5_busy_at_1", int'(bz_s[1]), 1);
        wait_idle();

        // Burst to full; the sixth byte is held until the first frame completes.
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), stall);
            check("burst_no_stall", stall, 0);
        end
        check("burst_full_count", int'(count), 4);
        check("burst_full_ready", int'(ready), 0);
        push(8'h06, stall);
        check("burst_hold_cycles", stall, 37);
        wait_idle();

        // Wrap-around with random valid gaps.
        for (int i = 0; i < 10; i++) begin
            push(8'h10 + 8'(i), stall);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();

        // Push during the STOP->START pop cycle with two bytes queued.
        push(8'h3C, stall);
        push(8'hC3, stall);
        push(8'h5A, stall);
        repeat (38) @(negedge clk);
        check("simul_pre_count", int'(count), 2);
        check("simul_pre_busy",  int'(busy),  1);
        push(8'h96, stall);
        check("simul_stall",      stall,       0);
        check("simul_post_count", int'(count), 2);
        check("simul_post_ready", int'(ready), 1);
        wait_idle();

        // Reset during DATA bit 3 of 8'hF0 with two bytes queued.
        push(8'hF0, stall);
        push(8'h33, stall);
        push(8'h44, stall);
        repeat (17) @(negedge clk);
        check("abort_pre_txd",   int'(txd),   0);
        check("abort_pre_count", int'(count), 2);
        #1 reset = 1'b1;
        #1;
        check("abort_txd",   int'(txd),   1);
        check("abort_busy",  int'(busy),  0);
        check("abort_count", int'(count), 0);
        check("abort_ready", int'(ready), 1);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("abort_quiet_busy",  int'(busy),  0);
        check("abort_quiet_txd",   int'(txd),   1);
        check("abort_quiet_count", int'(count), 0);

        // Random bytes with mixed gaps.
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom), stall);
            if ($urandom_range(0, 7) == 0) repeat (30) @(negedge clk);
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (10) @(negedge clk);

        check("rx_all_delivered", rx_exp.size(), 0);
        check("rx_any_received", int'(rx_got > 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
